// File: rtl/scpu_pkg.sv
// Shared definitions for the sCPU register-file side blocks.
package scpu_pkg;

    localparam int SCPU_DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        RRP_IDLE   = ST_IDLE,
        RRP_SAMPLE = ST_SAMPLE,
        RRP_RESP   = ST_RESP
    } rrp_state_e;

endpackage

// File: rtl/reg_select_mux.sv
// Combinational NUM_REGS:1 register selector. An index with no matching
// register returns zero data and raises the out-of-range flag.
module reg_select_mux #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int IDX_W    = 2
) (
    input  logic [IDX_W-1:0]           sel_i,
    input  logic [NUM_REGS*DATA_W-1:0] bus_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       oor_o
);

    // Select the matching slice; no match means the index is out of range.
    always_comb begin
        data_o = '0;
        oor_o  = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_i == IDX_W'(i)) begin
                data_o = bus_i[i*DATA_W +: DATA_W];
                oor_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// Read port for the sCPU enable registers: accepts an index, snapshots the
// selected register one cycle later and returns it on a valid/ready channel.
//
//  state  | meaning
//  IDLE   | ready for a request, req_ready high
//  SAMPLE | index latched, capture selected register next edge
//  RESP   | response held on rsp_* until the consumer accepts it
module reg_read_port
    import scpu_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = SCPU_DATA_W,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [IDX_W-1:0]           req_idx,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bus,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [7:0]                 read_count
);

    rrp_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic [7:0]        read_count_q;
    logic [7:0]        read_count_d;

    logic [DATA_W-1:0] sel_data;
    logic              sel_oor;

    reg_select_mux #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_sel (
        .sel_i  (idx_q),
        .bus_i  (reg_bus),
        .data_o (sel_data),
        .oor_o  (sel_oor)
    );

    // Completed-response counter, free-running modulo 256.
    always_comb begin
        read_count_d = read_count_q + 8'd1;
    end

    // Request/sample/response sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RRP_IDLE;
            idx_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            read_count_q <= '0;
        end else begin
            case (state_q)
                RRP_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        idx_q       <= req_idx;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= RRP_SAMPLE;
                    end
                end
                RRP_SAMPLE: begin
                    // Snapshot taken here; later reg_bus changes are not seen.
                    rsp_data_q  <= sel_data;
                    rsp_err_q   <= sel_oor;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RRP_RESP;
                end
                RRP_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        read_count_q <= read_count_d;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= RRP_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= RRP_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign read_count = read_count_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Directed bench for reg_read_port with three registers, so index 3 is
// out of range. Registers are modelled as write-enabled flops.
module tb_reg_read_port;

    localparam int NUM_REGS = 3;
    localparam int DATA_W   = 8;
    localparam int IDX_W    = 2;

    logic                       clk;
    logic                       rst;
    logic                       req_valid;
    logic                       req_ready;
    logic [IDX_W-1:0]           req_idx;
    logic [NUM_REGS*DATA_W-1:0] reg_bus;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_W-1:0]          rsp_data;
    logic                       rsp_err;
    logic                       busy;
    logic [7:0]                 read_count;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    int         n_vec;
    int         n_err;
    logic [7:0] exp_cnt;

    reg_read_port #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idx    (req_idx),
        .reg_bus    (reg_bus),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .read_count (read_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: a write enabled in a cycle lands on that cycle's closing edge.
    always @(posedge clk) begin
        if (wr_en) regs[wr_idx] <= wr_data;
    end

    assign reg_bus = {regs[2], regs[1], regs[0]};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Full read with rsp_ready held high; checks latency, payload and counter.
    task automatic do_read(input string tag, input logic [IDX_W-1:0] idx,
                           input logic [DATA_W-1:0] exp_data, input logic exp_err);
        check_eq({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_idx   = idx;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq({tag, ".busy_sample"}, 32'(busy), 32'd1);
        check_eq({tag, ".rsp_valid_early"}, 32'(rsp_valid), 32'd0);
        tick();
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check_eq({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check_eq({tag, ".rsp_valid_done"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".read_count"}, 32'(read_count), 32'(exp_cnt));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".read_count"}, 32'(read_count), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_cnt   = 8'd0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_idx   = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        regs[0]   = 8'h00;
        regs[1]   = 8'h00;
        regs[2]   = 8'h00;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst.req_ready", 32'(req_ready), 32'd1);
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst.rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.read_count", 32'(read_count), 32'd0);

        // Basic read
        write_reg(2'd2, 8'hA5);
        write_reg(2'd1, 8'h11);
        do_read("basic", 2'd2, 8'hA5, 1'b0);

        // Back-pressure with snapshot and ignored request during RESP
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_idx   = 2'd1;
        tick();
        req_idx   = 2'd2;
        tick();
        check_eq("bp.rsp_valid", 32'(rsp_valid), 32'd1);
        write_reg(2'd1, 8'h22);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.hold_data", 32'(rsp_data), 32'h11);
            check_eq("bp.hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp.req_ready_low", 32'(req_ready), 32'd0);
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check_eq("bp.done_valid", 32'(rsp_valid), 32'd0);
        check_eq("bp.read_count", 32'(read_count), 32'(exp_cnt));
        // Request held since RESP is taken only now, and reads idx 2.
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("bp.next_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp.next_data", 32'(rsp_data), 32'hA5);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check_eq("bp.next_count", 32'(read_count), 32'(exp_cnt));

        // Write-before-read: write enabled in the accept cycle
        wr_en     = 1'b1;
        wr_idx    = 2'd0;
        wr_data   = 8'h3C;
        req_valid = 1'b1;
        req_idx   = 2'd0;
        tick();
        wr_en     = 1'b0;
        req_valid = 1'b0;
        tick();
        check_eq("wbr.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("wbr.rsp_data", 32'(rsp_data), 32'h3C);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check_eq("wbr.read_count", 32'(read_count), 32'(exp_cnt));

        // Range: highest valid index, then out of range, then recovery
        do_read("range.last", 2'd2, 8'hA5, 1'b0);
        do_read("range.oor", 2'd3, 8'h00, 1'b1);
        do_read("range.after", 2'd1, 8'h22, 1'b0);

        // Reset during SAMPLE
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_idx   = 2'd2;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        check_idle("rst_sample");
        tick();
        tick();
        check_eq("rst_sample.no_rsp", 32'(rsp_valid), 32'd0);

        // Reset during RESP
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_idx   = 2'd2;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("rst_resp.in_resp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_resp");
        rsp_ready = 1'b1;
        tick();
        check_eq("rst_resp.no_rsp", 32'(rsp_valid), 32'd0);
        do_read("rst_resp.read1", 2'd1, 8'h22, 1'b0);

        // Counter wrap: clear, then 256 reads bring it back to zero
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            do_read("wrap", 2'(i % NUM_REGS), (i % NUM_REGS == 0) ? 8'h3C :
                    (i % NUM_REGS == 1) ? 8'h22 : 8'hA5, 1'b0);
        end
        check_eq("wrap.zero", 32'(read_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
